conf_serial_loader: RTL

Parametrised serial-to-configuration-bus loader. It deserialises a strobed serial bitstream into configuration words and buffers them in a small FIFO. It claims the shared configuration bus when that bus is free and issues one single-cycle write per word, with an auto-incrementing address. It sits in the configuration chain between the serial command path and the register file, inserted in the daisy-chained Conf_* bus (pass-through when not owning). Compared with the previous fixed 16-bit loader, it adds:
- a single clock domain;
- generic word and address widths and bit order;
- write buffering that tolerates a busy bus;
- partial-word handling;
- optional TMR on all state.

---
 rtl/conf_serial_loader.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/conf_serial_loader.sv
// conf_serial_loader
// Deserialises a strobed serial bitstream into configuration words, buffers
// them in a small FIFO and writes them onto the daisy-chained Conf_* bus while
// owning it. All state lives in one packed record so it can be triplicated
// and majority-voted as a unit when TMR is enabled.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | bus pass-through, no frame or drain in progress
// S_WAIT_BUS | frame seen, waiting for upstream Conf_Free_In
// S_OWN      | bus owned, head of FIFO presented, no write strobe
// S_WRITE    | bus owned, one-cycle write of FIFO head, pops at cycle end
module conf_serial_loader #(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    ADDR_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE     = '0,
    parameter int                    FIFO_DEPTH    = 4,
    parameter bit                    MSB_FIRST     = 1'b1,
    parameter bit                    FLUSH_PARTIAL = 1'b0,
    parameter bit                    TMR           = 1'b1
) (
    input  logic                  Clk_i,
    input  logic                  Reset_ni,
    input  logic                  SR_In_i,
    input  logic                  SR_Strobe_i,
    input  logic                  SR_Write_i,
    input  logic                  Conf_Write_In_i,
    input  logic [DATA_WIDTH-1:0] Conf_Data_In_i,
    input  logic [ADDR_WIDTH-1:0] Conf_Address_In_i,
    input  logic                  Conf_Free_In_i,
    output logic                  Conf_Write_Out_o,
    output logic [DATA_WIDTH-1:0] Conf_Data_Out_o,
    output logic [ADDR_WIDTH-1:0] Conf_Address_Out_o,
    output logic                  Conf_Free_Out_o,
    output logic                  Busy_o,
    output logic                  Overflow_o,
    output logic                  Partial_Drop_o
);

    localparam int CW    = $clog2(DATA_WIDTH + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = PW + 1;
    localparam int EW    = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_BUS = 2'd1,
        S_OWN      = 2'd2,
        S_WRITE    = 2'd3
    } fsm_e;

    typedef struct packed {
        fsm_e                           fsm;
        logic [DATA_WIDTH-1:0]          sr;
        logic [CW-1:0]                  cnt;
        logic [ADDR_WIDTH-1:0]          addr;
        logic [FIFO_DEPTH-1:0][EW-1:0]  mem;
        logic [PTR_W-1:0]               wptr;
        logic [PTR_W-1:0]               rptr;
        logic                           ovf;
        logic                           pdrop;
        logic                           wr_prev;
    } state_t;

    localparam int SW = $bits(state_t);

    localparam state_t ST_RST = '{
        fsm:     S_IDLE,
        sr:      '0,
        cnt:     '0,
        addr:    ADDR_BASE,
        mem:     '0,
        wptr:    '0,
        rptr:    '0,
        ovf:     1'b0,
        pdrop:   1'b0,
        wr_prev: 1'b0
    };

    state_t st_q;
    state_t st_d;

    logic                  rise;
    logic                  fall;
    logic [CW-1:0]         cnt_base;
    logic [ADDR_WIDTH-1:0] addr_base;
    logic [DATA_WIDTH-1:0] sr_shift;
    logic [DATA_WIDTH-1:0] padded;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [EW-1:0]         entry;
    logic [EW-1:0]         head;

    assign empty = (st_q.wptr == st_q.rptr);
    assign full  = (st_q.wptr[PW-1:0] == st_q.rptr[PW-1:0]) &&
                   (st_q.wptr[PW] != st_q.rptr[PW]);
    assign head  = st_q.mem[st_q.rptr[PW-1:0]];

    // Next-state for the whole block: deserialiser, address, FIFO, flags, FSM.
    always_comb begin
        st_d         = st_q;
        st_d.pdrop   = 1'b0;
        st_d.wr_prev = SR_Write_i;

        rise      = SR_Write_i & ~st_q.wr_prev;
        fall      = ~SR_Write_i & st_q.wr_prev;
        cnt_base  = rise ? '0 : st_q.cnt;
        addr_base = rise ? ADDR_BASE : st_q.addr;
        sr_shift  = MSB_FIRST ? {st_q.sr[DATA_WIDTH-2:0], SR_In_i}
                              : {SR_In_i, st_q.sr[DATA_WIDTH-1:1]};
        // Shifting out the stale bits of the previous word leaves zeros behind.
        padded    = MSB_FIRST ? (st_q.sr << (DATA_WIDTH - int'(st_q.cnt)))
                              : (st_q.sr >> (DATA_WIDTH - int'(st_q.cnt)));
        push      = 1'b0;
        entry     = '0;
        pop       = (st_q.fsm == S_WRITE);

        st_d.cnt  = cnt_base;
        st_d.addr = addr_base;
        if (rise) begin
            st_d.ovf = 1'b0;
        end

        if (SR_Write_i && SR_Strobe_i) begin
            st_d.sr = sr_shift;
            if (cnt_base == CW'(DATA_WIDTH - 1)) begin
                push      = 1'b1;
                entry     = {addr_base, sr_shift};
                st_d.cnt  = '0;
                st_d.addr = addr_base + ADDR_WIDTH'(1);
            end else begin
                st_d.cnt  = cnt_base + CW'(1);
            end
        end else if (fall && (st_q.cnt != '0)) begin
            st_d.cnt = '0;
            if (FLUSH_PARTIAL) begin
                push      = 1'b1;
                entry     = {st_q.addr, padded};
                st_d.addr = st_q.addr + ADDR_WIDTH'(1);
            end else begin
                st_d.pdrop = 1'b1;
            end
        end

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        if (push) begin
            if (!full || pop) begin
                st_d.mem[st_q.wptr[PW-1:0]] = entry;
                st_d.wptr = st_q.wptr + PTR_W'(1);
            end else begin
                st_d.ovf = 1'b1;
            end
        end
        if (pop) begin
            st_d.rptr = st_q.rptr + PTR_W'(1);
        end

        case (st_q.fsm)
            S_IDLE: begin
                if (SR_Write_i) st_d.fsm = S_WAIT_BUS;
            end
            S_WAIT_BUS: begin
                if (Conf_Free_In_i) st_d.fsm = S_OWN;
            end
            S_OWN: begin
                // wr_prev high means a frame end (and possible flush) is still due.
                if (!empty) begin
                    st_d.fsm = S_WRITE;
                end else if (!SR_Write_i && !st_q.wr_prev) begin
                    st_d.fsm = S_IDLE;
                end
            end
            S_WRITE: begin
                st_d.fsm = S_OWN;
            end
            default: begin
                st_d.fsm = S_IDLE;
            end
        endcase
    end

    generate
        if (TMR) begin : g_tmr
            logic [SW-1:0] st_a;
            logic [SW-1:0] st_b;
            logic [SW-1:0] st_c;

            // Three copies all reload from the voted next state, so a single upset heals in one edge.
            always_ff @(posedge Clk_i or negedge Reset_ni) begin
                if (!Reset_ni) begin
                    st_a <= ST_RST;
                    st_b <= ST_RST;
                    st_c <= ST_RST;
                end else begin
                    st_a <= st_d;
                    st_b <= st_d;
                    st_c <= st_d;
                end
            end

            assign st_q = state_t'((st_a & st_b) | (st_a & st_c) | (st_b & st_c));
        end else begin : g_single
            logic [SW-1:0] st_r;

            // Single copy of the state record.
            always_ff @(posedge Clk_i or negedge Reset_ni) begin
                if (!Reset_ni) begin
                    st_r <= ST_RST;
                end else begin
                    st_r <= st_d;
                end
            end

            assign st_q = state_t'(st_r);
        end
    endgenerate

    logic owning;
    assign owning = (st_q.fsm == S_OWN) || (st_q.fsm == S_WRITE);

    // Bus muxes select on registered state only; the write strobe is a decoded state bit.
    always_comb begin
        Conf_Data_Out_o    = owning ? head[DATA_WIDTH-1:0] : Conf_Data_In_i;
        Conf_Address_Out_o = owning ? head[EW-1:DATA_WIDTH] : Conf_Address_In_i;
        Conf_Write_Out_o   = owning ? (st_q.fsm == S_WRITE) : Conf_Write_In_i;
        Conf_Free_Out_o    = (st_q.fsm == S_IDLE) ? Conf_Free_In_i : 1'b0;
        Busy_o             = (st_q.fsm != S_IDLE);
        Overflow_o         = st_q.ovf;
        Partial_Drop_o     = st_q.pdrop;
    end

endmodule
